bank_refill_unit: RTL and testbench
===================================

BANK_REFILL_UNIT -- requirements
Module: bank_refill_unit

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 256, refill line width in bits; ID_WIDTH, default 8, AXI ID width; DEPTH, default 2, refill buffer entries (power of two, at least 2).
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 htu_alloc_valid_i  input  1  miss allocated to set_way, refill now outstanding.
REQ-005 htu_alloc_set_way_i  input  6  set/way index of the allocated miss.
REQ-006 biu_isu_rvalid_i  input  1  refill beat valid.
REQ-007 biu_isu_rready_o  output  1  refill beat accepted when high with rvalid.
REQ-008 biu_isu_rdata_i  input  DATA_WIDTH  refill line data.
REQ-009 biu_isu_rid_i  input  ID_WIDTH  response ID; bits [5:0] are set_way, upper bits are zero.
REQ-010 ram_req_o  output  1  data-RAM write request.
REQ-011 ram_gnt_i  input  1  data-RAM write grant; the write occurs in the cycle where req and gnt are both high.
REQ-012 ram_set_way_o  output  6  write index.
REQ-013 ram_wdata_o  output  DATA_WIDTH  write data.
REQ-014 refill_done_valid_o  output  1  refill complete notification to htu.
REQ-015 refill_done_ready_i  input  1  htu accepts the notification.
REQ-016 refill_done_set_way_o  output  6  set/way of the completed refill.
REQ-017 pending_o  output  64  outstanding-refill bitmap.
REQ-018 err_o  output  1  sticky protocol-error flag.

Function
REQ-019 The buffer SHALL be a DEPTH-entry FIFO of {set_way, data}; biu_isu_rready_o = (count < DEPTH), driven from registers only, with no combinational path from ram_gnt_i.
REQ-020 A beat SHALL be accepted when rvalid and rready are both high; it is pushed only if rid[5:0] is set in pending_o and rid[ID_WIDTH-1:6] equals 0.
REQ-021 Otherwise the beat SHALL be consumed and dropped, and err_o set.
REQ-022 Simultaneous push and pop SHALL keep the count unchanged; pointers wrap modulo DEPTH.
REQ-023 The FSM SHALL have states IDLE, REQ and DONE, with transitions:
- IDLE -> REQ when the FIFO is non-empty.
- REQ -> DONE when ram_gnt_i is high.
- DONE -> IDLE when refill_done_ready_i is high.
REQ-024 In REQ, ram_req_o SHALL be 1 and ram_set_way_o/ram_wdata_o SHALL show the FIFO head; the head pops in the grant cycle.
REQ-025 The popped set_way SHALL be held in a register.
REQ-026 In DONE, refill_done_valid_o SHALL be 1 with the held set_way; ram_req_o SHALL be 0.
REQ-027 Minimum latency SHALL be: accept at cycle N, ram_req_o at N+2, done_valid at N+3 when granted at N+2.
REQ-028 Outputs SHALL stay stable while req or valid is held awaiting gnt or ready.
REQ-029 pending_o[k] SHALL be set by an alloc with set_way k.
REQ-030 pending_o[k] SHALL be cleared on the done handshake for k.
REQ-031 If alloc and clear target the same k in the same cycle, the set SHALL win.
REQ-032 An alloc to an index already pending (and not being cleared that cycle) SHALL set err_o; the bit stays 1.
REQ-033 err_o SHALL clear only on reset.

Reset
REQ-034 While rst_ni is low, state SHALL be IDLE; FIFO pointers and count SHALL be 0; pending_o, err_o, ram_req_o, refill_done_valid_o and the held set_way SHALL be 0.
REQ-035 Immediately after reset, biu_isu_rready_o SHALL be 1.
REQ-036 Reset asserted mid-operation SHALL abandon the buffered beats and any in-progress request, with no further RAM write.

Verification
REQ-037 Alloc 0x05; beat rid=0x05, data=A; gnt held high -> ram_req_o at N+2 with set_way 0x05, data A; done_valid at N+3; pending_o[5] clears after ready.
REQ-038 Allocs 0x01, 0x02; two back-to-back beats; gnt low -> rready drops to 0 after the 2nd beat; raising gnt yields writes 0x01 then 0x02 in order.
REQ-039 Beat rid=0x09 with pending_o[9]=0 -> beat consumed, no ram_req_o, err_o=1 and stays 1.
REQ-040 Beat rid=0x45 (upper bits nonzero) -> beat dropped, err_o=1.
REQ-041 Done handshake for 0x03 coincides with a new alloc 0x03 -> pending_o[3] stays 1, err_o stays 0.
REQ-042 rst_ni pulsed low during REQ with 2 entries buffered -> all outputs at reset values, rready=1, and no write after release.

Source files
------------

// File: rtl/bank_refill_unit.sv
// bank_refill_unit: buffers refill beats for allocated misses and writes them into the data RAM,
// then notifies the hit/tag unit; tracks outstanding refills and flags protocol errors.
module bank_refill_unit #(
   parameter int DATA_WIDTH = 256,
   parameter int ID_WIDTH   = 8,
   parameter int DEPTH      = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  htu_alloc_valid_i,
   input  logic [5:0]            htu_alloc_set_way_i,
   input  logic                  biu_isu_rvalid_i,
   output logic                  biu_isu_rready_o,
   input  logic [DATA_WIDTH-1:0] biu_isu_rdata_i,
   input  logic [ID_WIDTH-1:0]   biu_isu_rid_i,
   output logic                  ram_req_o,
   input  logic                  ram_gnt_i,
   output logic [5:0]            ram_set_way_o,
   output logic [DATA_WIDTH-1:0] ram_wdata_o,
   output logic                  refill_done_valid_o,
   input  logic                  refill_done_ready_i,
   output logic [5:0]            refill_done_set_way_o,
   output logic [63:0]           pending_o,
   output logic                  err_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   state_t state_q, state_d;
   logic [5:0] sw_mem_q [DEPTH];
   logic [5:0] sw_mem_d [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem_d [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [63:0] pending_q, pending_d, set_mask, clr_mask;
   logic [5:0] held_q, held_d;
   logic err_q, err_d;
   logic accept, rid_ok, push, pop, done_hs;

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) state_q <= IDLE;
      else state_q <= state_d;

   always_comb
      state_d = (state_q == IDLE && cnt_q != '0) ? REQ :
                (state_q == REQ && ram_gnt_i) ? DONE :
                (state_q == DONE && refill_done_ready_i) ? IDLE : state_q;

   always_comb begin
      ram_req_o             = state_q == REQ;
      refill_done_valid_o   = state_q == DONE;
      ram_set_way_o         = sw_mem_q[rptr_q];
      ram_wdata_o           = data_mem_q[rptr_q];
      refill_done_set_way_o = held_q;
      biu_isu_rready_o      = cnt_q != CW'(DEPTH);
      pending_o             = pending_q;
      err_o                 = err_q;
   end

   // A beat is only buffered for an outstanding refill with a well-formed ID; anything else is dropped.
   always_comb begin
      accept     = biu_isu_rvalid_i && biu_isu_rready_o;
      rid_ok     = pending_q[biu_isu_rid_i[5:0]] && (biu_isu_rid_i >> 6) == '0;
      push       = accept && rid_ok;
      pop        = ram_req_o && ram_gnt_i;
      done_hs    = refill_done_valid_o && refill_done_ready_i;
      sw_mem_d   = sw_mem_q;
      data_mem_d = data_mem_q;
      if (push) begin
         sw_mem_d[wptr_q]   = biu_isu_rid_i[5:0];
         data_mem_d[wptr_q] = biu_isu_rdata_i;
      end
      wptr_d    = wptr_q + PW'(push);
      rptr_d    = rptr_q + PW'(pop);
      cnt_d     = cnt_q + CW'(push) - CW'(pop);
      held_d    = pop ? ram_set_way_o : held_q;
      set_mask  = htu_alloc_valid_i ? 64'd1 << htu_alloc_set_way_i : '0;
      clr_mask  = done_hs ? 64'd1 << held_q : '0;
      pending_d = (pending_q & ~clr_mask) | set_mask;
      err_d     = err_q | (accept && !rid_ok) | (|(set_mask & pending_q & ~clr_mask));
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         sw_mem_q   <= '{default: '0};
         data_mem_q <= '{default: '0};
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         pending_q  <= '0;
         held_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         sw_mem_q   <= sw_mem_d;
         data_mem_q <= data_mem_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         pending_q  <= pending_d;
         held_q     <= held_d;
         err_q      <= err_d;
      end
endmodule

// File: tb/tb_bank_refill_unit.sv
// tb_bank_refill_unit: directed and randomized refill traffic checked by a queue-based scoreboard.
module tb_bank_refill_unit;
   localparam int DW = 256, IW = 8, DEPTH = 2;
   logic clk_i = 1'b0, rst_ni = 1'b0;
   logic htu_alloc_valid_i = 1'b0;
   logic [5:0] htu_alloc_set_way_i = '0;
   logic biu_isu_rvalid_i = 1'b0, biu_isu_rready_o;
   logic [DW-1:0] biu_isu_rdata_i = '0;
   logic [IW-1:0] biu_isu_rid_i = '0;
   logic ram_req_o, ram_gnt_i = 1'b0;
   logic [5:0] ram_set_way_o, refill_done_set_way_o;
   logic [DW-1:0] ram_wdata_o;
   logic refill_done_valid_o, refill_done_ready_i = 1'b0;
   logic [63:0] pending_o;
   logic err_o;

   bank_refill_unit #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .htu_alloc_valid_i(htu_alloc_valid_i), .htu_alloc_set_way_i(htu_alloc_set_way_i),
      .biu_isu_rvalid_i(biu_isu_rvalid_i), .biu_isu_rready_o(biu_isu_rready_o),
      .biu_isu_rdata_i(biu_isu_rdata_i), .biu_isu_rid_i(biu_isu_rid_i),
      .ram_req_o(ram_req_o), .ram_gnt_i(ram_gnt_i), .ram_set_way_o(ram_set_way_o),
      .ram_wdata_o(ram_wdata_o), .refill_done_valid_o(refill_done_valid_o),
      .refill_done_ready_i(refill_done_ready_i), .refill_done_set_way_o(refill_done_set_way_o),
      .pending_o(pending_o), .err_o(err_o));

   always #5 clk_i = ~clk_i;

   int checks = 0, errors = 0, wr_cnt = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd();
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic alloc(input logic [5:0] k);
      htu_alloc_valid_i = 1'b1;
      htu_alloc_set_way_i = k;
      cyc();
      htu_alloc_valid_i = 1'b0;
   endtask

   task automatic beat(input logic [IW-1:0] id, input logic [DW-1:0] d);
      biu_isu_rvalid_i = 1'b1;
      biu_isu_rid_i = id;
      biu_isu_rdata_i = d;
      cyc();
      biu_isu_rvalid_i = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_ni = 1'b0;
      cyc();
      rst_ni = 1'b1;
      cyc();
   endtask

   // Reference model: beats awaiting their RAM write, writes awaiting their done handshake,
   // the outstanding-refill set and the sticky error.
   typedef struct {logic [5:0] sw; logic [DW-1:0] d;} ent_t;
   ent_t exp_wr[$];
   logic [5:0] exp_done[$];
   logic [63:0] m_pend = '0;
   logic m_err = 1'b0, m_rdy, m_clr;
   logic [5:0] m_clr_k;

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         exp_wr.delete();
         exp_done.delete();
         m_pend = '0;
         m_err = 1'b0;
         chk("rst_ram_req", ram_req_o, 0);
         chk("rst_done_valid", refill_done_valid_o, 0);
         chk("rst_pending", pending_o, 0);
         chk("rst_err", err_o, 0);
         chk("rst_rready", biu_isu_rready_o, 1);
      end else begin
         m_rdy = exp_wr.size() < DEPTH;
         m_clr = 1'b0;
         m_clr_k = '0;
         chk("rready", biu_isu_rready_o, m_rdy);
         chk("pending", pending_o, m_pend);
         chk("err", err_o, m_err);
         if (refill_done_valid_o) begin
            if (exp_done.size() == 0) chk("spurious_done", refill_done_valid_o, 0);
            else begin
               chk("done_sw", refill_done_set_way_o, exp_done[0]);
               if (refill_done_ready_i) begin
                  m_clr = 1'b1;
                  m_clr_k = exp_done.pop_front();
               end
            end
         end
         if (ram_req_o) begin
            if (exp_wr.size() == 0) chk("spurious_req", ram_req_o, 0);
            else begin
               chk("wr_sw", ram_set_way_o, exp_wr[0].sw);
               chk("wr_data", ram_wdata_o, exp_wr[0].d);
               if (ram_gnt_i) begin
                  exp_done.push_back(exp_wr[0].sw);
                  void'(exp_wr.pop_front());
                  wr_cnt++;
               end
            end
         end
         if (htu_alloc_valid_i && m_pend[htu_alloc_set_way_i] && !(m_clr && m_clr_k == htu_alloc_set_way_i))
            m_err = 1'b1;
         if (biu_isu_rvalid_i && m_rdy) begin
            if (m_pend[biu_isu_rid_i[5:0]] && biu_isu_rid_i[IW-1:6] == '0)
               exp_wr.push_back('{biu_isu_rid_i[5:0], biu_isu_rdata_i});
            else m_err = 1'b1;
         end
         if (m_clr) m_pend[m_clr_k] = 1'b0;
         if (htu_alloc_valid_i) m_pend[htu_alloc_set_way_i] = 1'b1;
      end
   end

   logic [DW-1:0] da;
   logic seen;
   int start;
   logic found, bad_ok;

   initial begin
      repeat (3) cyc();
      rst_ni = 1'b1;
      chk("rready_after_rst", biu_isu_rready_o, 1);
      cyc();
      // minimum latency with grant and ready held high
      ram_gnt_i = 1'b1;
      refill_done_ready_i = 1'b1;
      alloc(6'h05);
      da = rnd();
      beat(8'h05, da);
      chk("lat_n1_req", ram_req_o, 0);
      cyc();
      chk("lat_n2_req", ram_req_o, 1);
      chk("lat_n2_sw", ram_set_way_o, 6'h05);
      chk("lat_n2_data", ram_wdata_o, da);
      cyc();
      chk("lat_n3_done", refill_done_valid_o, 1);
      chk("lat_n3_sw", refill_done_set_way_o, 6'h05);
      chk("lat_n3_req", ram_req_o, 0);
      cyc();
      chk("pend5_clear", pending_o[5], 0);
      // back-pressure with grant withheld, then in-order drain
      ram_gnt_i = 1'b0;
      alloc(6'h01);
      alloc(6'h02);
      beat(8'h01, rnd());
      beat(8'h02, rnd());
      chk("rready_full", biu_isu_rready_o, 0);
      repeat (3) cyc();
      chk("rready_still_full", biu_isu_rready_o, 0);
      ram_gnt_i = 1'b1;
      repeat (8) cyc();
      chk("rready_drained", biu_isu_rready_o, 1);
      chk("wr_cnt_ordered", wr_cnt, 3);
      // done handshake coincides with a new alloc to the same index
      refill_done_ready_i = 1'b0;
      alloc(6'h03);
      beat(8'h03, rnd());
      for (int i = 0; i < 20 && !refill_done_valid_o; i++) cyc();
      chk("wait_done3", refill_done_valid_o, 1);
      refill_done_ready_i = 1'b1;
      alloc(6'h03);
      chk("pend3_kept", pending_o[3], 1);
      chk("err_no_realloc", err_o, 0);
      // reset in REQ with two entries buffered
      ram_gnt_i = 1'b0;
      alloc(6'h01);
      alloc(6'h02);
      beat(8'h01, rnd());
      beat(8'h02, rnd());
      for (int i = 0; i < 20 && !ram_req_o; i++) cyc();
      chk("wait_req_rst", ram_req_o, 1);
      rst_ni = 1'b0;
      #1;
      chk("midrst_req", ram_req_o, 0);
      chk("midrst_rready", biu_isu_rready_o, 1);
      chk("midrst_pending", pending_o, 0);
      cyc();
      rst_ni = 1'b1;
      ram_gnt_i = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         seen |= ram_req_o;
      end
      chk("no_write_after_rst", seen, 0);
      // malformed ID on an outstanding index
      alloc(6'h05);
      beat(8'h45, rnd());
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         seen |= ram_req_o;
         cyc();
      end
      chk("bad_id_no_req", seen, 0);
      chk("bad_id_err", err_o, 1);
      chk("bad_id_pend5", pending_o[5], 1);
      pulse_reset();
      // beat for an index with no outstanding refill
      beat(8'h09, rnd());
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         seen |= ram_req_o;
         cyc();
      end
      chk("unalloc_no_req", seen, 0);
      chk("unalloc_err", err_o, 1);
      repeat (5) cyc();
      chk("unalloc_err_sticky", err_o, 1);
      pulse_reset();
      // randomized traffic: clean first, protocol errors allowed later
      for (int n = 0; n < 2000; n++) begin
         bad_ok = n >= 1200;
         ram_gnt_i = ($urandom % 3) != 0;
         refill_done_ready_i = ($urandom % 3) != 0;
         htu_alloc_set_way_i = 6'($urandom);
         htu_alloc_valid_i = ($urandom % 4 == 0) &&
            (!pending_o[htu_alloc_set_way_i] || (bad_ok && $urandom % 8 == 0));
         start = int'($urandom % 64);
         found = 1'b0;
         for (int j = 0; j < 64; j++)
            if (!found && pending_o[(start + j) % 64]) begin
               found = 1'b1;
               biu_isu_rid_i = IW'((start + j) % 64);
            end
         biu_isu_rvalid_i = found && ($urandom % 2 == 0);
         if (bad_ok && $urandom % 16 == 0) begin
            biu_isu_rvalid_i = 1'b1;
            biu_isu_rid_i = IW'($urandom);
         end
         biu_isu_rdata_i = rnd();
         cyc();
      end
      htu_alloc_valid_i = 1'b0;
      biu_isu_rvalid_i = 1'b0;
      ram_gnt_i = 1'b1;
      refill_done_ready_i = 1'b1;
      for (int i = 0; i < 100 && (exp_wr.size() != 0 || exp_done.size() != 0 || ram_req_o || refill_done_valid_o); i++)
         cyc();
      chk("drain_idle", {ram_req_o, refill_done_valid_o}, 2'b00);
      chk("drain_writes", exp_wr.size() + exp_done.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
